lpc_ringbuf_ctrl: RTL and testbench

Ring-buffer controller for the LPC capture RAM. It owns the slot allocation: it drives target_addr to the LPC-to-RAM writer and advances the write slot on each completed frame. On the read side it sequences the RAM read port and streams the captured frame bytes out over a valid/ready byte interface toward the UART/host readout. It also tracks occupancy and counts frames dropped on overflow.

---
 rtl/lpc_capture_pkg.sv | 28 ++
 rtl/lpc_slot_ptrs.sv | 61 ++++++
 rtl/lpc_ringbuf_ctrl.sv | 110 +++++++++++
 tb/tb_lpc_ringbuf_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_capture_pkg.sv
// ------------------------------------------------------------------
// lpc_capture_pkg: shared constants and read-FSM encoding for LPC capture
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package lpc_capture_pkg;

  // Byte layout of one captured frame inside its RAM slot
  localparam int IDX_TYPE  = 0;
  localparam int IDX_ADDR3 = 1;
  localparam int IDX_ADDR2 = 2;
  localparam int IDX_ADDR1 = 3;
  localparam int IDX_ADDR0 = 4;
  localparam int IDX_DATA  = 5;

  localparam int FRAME_BYTES_DEFAULT = IDX_DATA + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/lpc_slot_ptrs.sv
// ------------------------------------------------------------------
// lpc_slot_ptrs: ring pointers, occupancy flags, frame edge detect, drop counter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lpc_slot_ptrs #(
  parameter int SLOT_BITS = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic                 rd_advance,
  output logic [SLOT_BITS-1:0] target_addr,
  output logic [SLOT_BITS-1:0] rd_slot,
  output logic                 empty,
  output logic                 full,
  output logic [7:0]           overflow_count
);

  localparam logic [SLOT_BITS:0] PTR_ONE    = {{SLOT_BITS{1'b0}}, 1'b1};
  // One slot stays reserved as the writer's scratch slot
  localparam logic [SLOT_BITS:0] FULL_COUNT = {1'b0, {SLOT_BITS{1'b1}}};

  logic [SLOT_BITS:0] wr_ptr;
  logic [SLOT_BITS:0] rd_ptr;
  logic [SLOT_BITS:0] count;
  logic               fd_prev;
  logic               new_frame;

  assign new_frame   = frame_done & ~fd_prev;
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign full        = (count == FULL_COUNT);
  assign target_addr = wr_ptr[SLOT_BITS-1:0];
  assign rd_slot     = rd_ptr[SLOT_BITS-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fd_prev        <= 1'b1;
      overflow_count <= 8'd0;
    end else begin
      fd_prev <= frame_done;
      if (new_frame) begin
        if (!full) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end else if (overflow_count != 8'hFF) begin
          overflow_count <= overflow_count + 8'd1;
        end
      end
      if (rd_advance) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lpc_ringbuf_ctrl.sv
// ------------------------------------------------------------------
// lpc_ringbuf_ctrl: capture ring-buffer controller with valid/ready byte readout
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lpc_ringbuf_ctrl
  import lpc_capture_pkg::*;
#(
  parameter int SLOT_BITS   = 5,
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_done,
  output logic [SLOT_BITS-1:0] target_addr,
  output logic [SLOT_BITS+2:0] ram_rd_addr,
  input  logic [7:0]           ram_rd_data,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 empty,
  output logic                 full,
  output logic [7:0]           overflow_count
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  rd_state_t              state, state_n;
  logic [2:0]             idx, idx_n;
  logic [SLOT_BITS+2:0]   addr_n;
  logic [7:0]             data_n;
  logic                   valid_n;
  logic                   rd_advance;
  logic [SLOT_BITS-1:0]   rd_slot;

  lpc_slot_ptrs #(
    .SLOT_BITS (SLOT_BITS)
  ) u_ptrs (
    .clock          (clock),
    .reset          (reset),
    .frame_done     (frame_done),
    .rd_advance     (rd_advance),
    .target_addr    (target_addr),
    .rd_slot        (rd_slot),
    .empty          (empty),
    .full           (full),
    .overflow_count (overflow_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= 3'(IDX_TYPE);
      ram_rd_addr <= '0;
      out_data    <= 8'd0;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      ram_rd_addr <= addr_n;
      out_data    <= data_n;
      out_valid   <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    addr_n     = ram_rd_addr;
    data_n     = out_data;
    valid_n    = out_valid;
    rd_advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          addr_n  = {rd_slot, idx};
          state_n = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        data_n  = ram_rd_data;
        valid_n = 1'b1;
        state_n = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Byte is held until the sink takes it; the slot is released on the last byte
        if (out_ready) begin
          valid_n = 1'b0;
          if (idx == LAST_IDX) begin
            idx_n      = 3'd0;
            rd_advance = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            idx_n   = idx + 3'd1;
            addr_n  = {rd_slot, idx_n};
            state_n = ST_ADDR;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lpc_ringbuf_ctrl.sv
// ------------------------------------------------------------------
// tb_lpc_ringbuf_ctrl: scoreboard bench with a queue-based ring-buffer model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_lpc_ringbuf_ctrl;

  localparam int SB    = 5;
  localparam int FB    = 6;
  localparam int NSLOT = 1 << SB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_done = 1'b0;
  logic [SB-1:0] target_addr;
  logic [SB+2:0] ram_rd_addr;
  logic [7:0]    ram_rd_data = 8'd0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          empty;
  logic          full;
  logic [7:0]    overflow_count;

  logic [7:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] exp_q[$];
  int m_count = 0, m_wr = 0, m_ovf = 0, m_pos = 0;
  logic m_fdp = 1'b1, m_rst_seen = 1'b0;
  logic p_valid = 1'b0, p_hs = 1'b0, p_empty = 1'b1;
  logic [7:0] p_data = 8'd0;
  int cyc = 0, empty_fall = 0;
  int hs_cyc[$];

  lpc_ringbuf_ctrl #(.SLOT_BITS(SB), .FRAME_BYTES(FB)) dut (
    .clock          (clk),
    .reset          (reset),
    .frame_done     (frame_done),
    .target_addr    (target_addr),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (ram_rd_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .empty          (empty),
    .full           (full),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples mid-cycle; inputs only change just after rising edges.
  always @(negedge clk) begin
    logic hs, nf, last;
    cyc++;
    chk("empty", empty, m_count == 0);
    chk("full", full, m_count == NSLOT - 1);
    chk("target_addr", target_addr, m_wr);
    chk("overflow_count", overflow_count, m_ovf);
    if (m_rst_seen) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_rd_addr", ram_rd_addr, 0);
      chk("rst_data", out_data, 0);
    end else if (p_valid && !p_hs) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, p_data);
    end
    if (p_empty && !empty) empty_fall = cyc;
    hs   = out_valid && out_ready && !reset;
    last = 1'b0;
    if (hs) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
      m_pos++;
      if (m_pos == FB) begin
        m_pos = 0;
        last  = 1'b1;
      end
    end
    nf      = frame_done && !m_fdp;
    p_valid = out_valid;
    p_data  = out_data;
    p_hs    = hs;
    p_empty = empty;
    if (reset) begin
      exp_q.delete();
      m_count = 0; m_wr = 0; m_ovf = 0; m_pos = 0;
      m_fdp = 1'b1;
      m_rst_seen = 1'b1;
    end else begin
      m_rst_seen = 1'b0;
      // full is judged on the occupancy before this edge's read completes
      if (nf) begin
        if (m_count == NSLOT - 1) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          for (int i = 0; i < FB; i++) exp_q.push_back(mem[m_wr * 8 + i]);
          m_wr = (m_wr + 1) % NSLOT;
          m_count++;
        end
      end
      if (last) m_count--;
      m_fdp = frame_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic load_slot(input logic [8*FB-1:0] b);
    for (int i = 0; i < FB; i++) mem[m_wr * 8 + i] = b[8*(FB-1-i) +: 8];
  endtask

  task automatic send_frame(input logic [8*FB-1:0] b, input int gap);
    tick();
    load_slot(b);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_rand(input int gap);
    send_frame({$urandom, $urandom}, gap);
  endtask

  // frame edge and final-byte handshake land on the same clock edge
  task automatic send_aligned(input logic [8*FB-1:0] b);
    load_slot(b);
    frame_done = 1'b1;
    out_ready  = 1'b1;
    tick();
    frame_done = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  task automatic accept_byte(input int hold);
    wait_valid();
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    tick();
    out_ready = 1'b1;
    while ((m_count != 0 || out_valid) && n < 4000) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_count", m_count, 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    bit done;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_empty", empty, 1);
    chk("reset_valid", out_valid, 0);

    // single frame: latency and byte spacing
    hs_cyc.delete();
    tick();
    out_ready = 1'b1;
    send_frame(48'h05_12_34_56_78_AB, 0);
    chk("single_target", target_addr, 1);
    drain();
    chk("single_bytes", hs_cyc.size(), FB);
    if (hs_cyc.size() == FB) begin
      chk("first_latency", hs_cyc[0] - empty_fall, 3);
      for (int i = 1; i < FB; i++) chk("byte_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
    end
    chk("single_empty", empty, 1);

    // backpressure on byte 2
    send_frame(48'h05_12_34_56_78_AB, 0);
    accept_byte(0);
    accept_byte(0);
    wait_valid();
    repeat (10) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h34);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) accept_byte(0);
    drain();

    // full / overflow
    do_reset();
    for (int i = 0; i < 33; i++) begin
      send_rand(0);
      if (i == 30) chk("full_at_31", full, 1);
    end
    chk("ovf_target", target_addr, NSLOT - 1);
    chk("ovf_count", overflow_count, 2);
    for (int i = 0; i < FB; i++) accept_byte(0);
    tick();
    chk("full_cleared", full, 0);
    drain();

    // wrap-around with continuous readout
    do_reset();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) send_rand($urandom_range(5, 25));
    drain();
    chk("wrap_ovf", overflow_count, 0);
    chk("wrap_target", target_addr, 40 % NSLOT);

    // simultaneous frame and final handshake, not full
    do_reset();
    for (int i = 0; i < 3; i++) send_rand(0);
    for (int i = 0; i < FB - 1; i++) accept_byte(0);
    wait_valid();
    send_aligned({$urandom, $urandom});
    chk("simul_target", target_addr, 4);
    chk("simul_empty", empty, 0);
    drain();

    // simultaneous frame and final handshake while full
    do_reset();
    for (int i = 0; i < NSLOT - 1; i++) send_rand(0);
    for (int i = 0; i < FB - 1; i++) accept_byte(0);
    wait_valid();
    send_aligned({$urandom, $urandom});
    chk("simul_full_ovf", overflow_count, 1);
    chk("simul_full_target", target_addr, NSLOT - 1);
    chk("simul_full_flag", full, 0);
    drain();

    // random traffic with random sink readiness
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) send_rand($urandom_range(0, 10));
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // reset mid-stream with frame_done held high across release
    do_reset();
    send_rand(0);
    wait_valid();
    frame_done = 1'b1;
    reset = 1'b1;
    tick();
    chk("midrst_valid", out_valid, 0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("level_empty", empty, 1);
    chk("level_target", target_addr, 0);
    frame_done = 1'b0;
    send_rand(0);
    chk("after_level_target", target_addr, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
